// File: rtl/block_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : block_plotter
//  Description : Draws a SIZE x SIZE solid-colour square into a VGA adapter,
//                one pixel per clock in row-major order, starting at a
//                latched top-left corner (x0, y0).
//
//                The optional macro PLOT_CLIP_EN suppresses the write strobe
//                for pixels that fall off the right or bottom edge. Timing is
//                the same with or without the macro.
//
//                Without the macro every pixel is written, and the
//                coordinates wrap to the width of the output ports.
//  Revision    : 1.0  initial release
// ============================================================================
module block_plotter #(
    parameter int SIZE  = 4,    // block side length in pixels (1..16)
    parameter int X_MAX = 160,  // screen width
    parameter int Y_MAX = 120   // screen height
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] xpos,
    input  logic [7:0] ypos,
    input  logic [2:0] color_draw,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DRAW = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Last column/row index. Four bits cover the largest legal SIZE of 16.
    localparam logic [3:0] c_LAST = 4'(SIZE - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [7:0] r_x0;
    logic [7:0] r_y0;
    logic [2:0] r_colour;

    // The counters hold the offset of the pixel that is currently on the
    // output registers, not the offset of the next pixel.
    logic [3:0] r_cx;
    logic [3:0] r_cy;

    // ------------------------------------------------------------------------
    // Next-pixel computation
    // ------------------------------------------------------------------------
    logic       w_accept;
    logic       w_row_end;
    logic       w_last_pixel;
    logic [3:0] w_next_cx;
    logic [3:0] w_next_cy;
    logic [7:0] w_base_x;
    logic [7:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [8:0] w_sum_y;
    logic       w_in_range;
    logic       w_plot;

    assign w_accept     = (r_state == c_ST_IDLE) && start;
    assign w_row_end    = (r_cx == c_LAST);
    assign w_last_pixel = w_row_end && (r_cy == c_LAST);

    // On accept, the first pixel comes straight from the inputs so that it
    // appears on the outputs in the very next cycle.
    assign w_next_cx = w_accept  ? 4'd0 :
                       w_row_end ? 4'd0 : (r_cx + 4'd1);
    assign w_next_cy = w_accept  ? 4'd0 :
                       w_row_end ? (r_cy + 4'd1) : r_cy;

    assign w_base_x = w_accept ? xpos : r_x0;
    assign w_base_y = w_accept ? ypos : r_y0;

    // Sums are nine bits wide so that the range test can see any overflow
    // past the 8-bit port width.
    assign w_sum_x = {1'b0, w_base_x} + {5'd0, w_next_cx};
    assign w_sum_y = {1'b0, w_base_y} + {5'd0, w_next_cy};

    assign w_in_range = (w_sum_x < 9'(X_MAX)) && (w_sum_y < 9'(Y_MAX));

`ifdef PLOT_CLIP_EN
    // Clipped pixels still use their cycle. Only the strobe is dropped.
    assign w_plot = w_in_range;
`else
    // No clipping: every pixel is written, and the range result is unused.
    logic w_unused;
    assign w_unused = w_in_range;
    assign w_plot   = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Control FSM. Every output is registered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_ST_IDLE;
            r_x0       <= 8'd0;
            r_y0       <= 8'd0;
            r_colour   <= 3'd0;
            r_cx       <= 4'd0;
            r_cy       <= 4'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    done     <= 1'b0;
                    vga_plot <= 1'b0;
                    if (start) begin
                        r_x0       <= xpos;
                        r_y0       <= ypos;
                        r_colour   <= color_draw;
                        r_cx       <= w_next_cx;
                        r_cy       <= w_next_cy;
                        vga_x      <= w_sum_x[7:0];
                        vga_y      <= w_sum_y[6:0];
                        vga_colour <= color_draw;
                        vga_plot   <= w_plot;
                        busy       <= 1'b1;
                        r_state    <= c_ST_DRAW;
                    end
                end

                c_ST_DRAW: begin
                    if (w_last_pixel) begin
                        // Keep the last coordinates and colour on the
                        // outputs; only the strobe drops.
                        vga_plot <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_cx       <= w_next_cx;
                        r_cy       <= w_next_cy;
                        vga_x      <= w_sum_x[7:0];
                        vga_y      <= w_sum_y[6:0];
                        vga_colour <= r_colour;
                        vga_plot   <= w_plot;
                    end
                end

                c_ST_DONE: begin
                    // A start seen in this cycle is ignored. The next
                    // request is accepted from IDLE.
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    vga_plot <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_block_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_block_plotter
//  Description : Directed self-checking bench for block_plotter. It uses a
//                SIZE=4 instance for the main cases and a SIZE=1 instance for
//                the single-pixel case. Expected plot strobes follow
//                PLOT_CLIP_EN when that macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_block_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] xpos;
    logic [7:0] ypos;
    logic [2:0] color_draw;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    logic       start1;
    logic [7:0] xpos1;
    logic [7:0] ypos1;
    logic [2:0] color1;
    logic [7:0] vga_x1;
    logic [6:0] vga_y1;
    logic [2:0] vga_colour1;
    logic       vga_plot1;
    logic       busy1;
    logic       done1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    block_plotter #(.SIZE(4), .X_MAX(160), .Y_MAX(120)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .xpos       (xpos),
        .ypos       (ypos),
        .color_draw (color_draw),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    block_plotter #(.SIZE(1), .X_MAX(160), .Y_MAX(120)) u_dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start1),
        .xpos       (xpos1),
        .ypos       (ypos1),
        .color_draw (color1),
        .vga_x      (vga_x1),
        .vga_y      (vga_y1),
        .vga_colour (vga_colour1),
        .vga_plot   (vga_plot1),
        .busy       (busy1),
        .done       (done1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // This task is entered at a negedge while the SIZE=4 instance is idle.
    // It issues one request and then checks every cycle through the return
    // to IDLE. The inputs are inverted during the draw; with hold=1, start
    // stays high. In both cases the block in progress must not change.
    task automatic draw_block(input logic [7:0] x, input logic [7:0] y,
                              input logic [2:0] c, input bit hold);
        logic [8:0] ex;
        logic [8:0] ey;
        logic       eplot;
        start      = 1'b1;
        xpos       = x;
        ypos       = y;
        color_draw = c;
        @(negedge clk);
        start      = hold;
        xpos       = ~x;
        ypos       = ~y;
        color_draw = ~c;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                ex = {1'b0, x} + 9'(k);
                ey = {1'b0, y} + 9'(r);
`ifdef PLOT_CLIP_EN
                eplot = (ex < 9'd160) && (ey < 9'd120);
`else
                eplot = 1'b1;
`endif
                check("plot", 32'(vga_plot), 32'(eplot));
                if (eplot) begin
                    check("vga_x", 32'(vga_x), 32'(ex[7:0]));
                    check("vga_y", 32'(vga_y), 32'(ey[6:0]));
                    check("colour", 32'(vga_colour), 32'(c));
                end
                check("busy_draw", 32'(busy), 32'd1);
                check("done_draw", 32'(done), 32'd0);
                @(negedge clk);
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        check("plot_done", 32'(vga_plot), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        check("colour_hold", 32'(vga_colour), 32'(c));
        @(negedge clk);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_idle", 32'(done), 32'd0);
        check("plot_idle", 32'(vga_plot), 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        xpos       = 8'd0;
        ypos       = 8'd0;
        color_draw = 3'd0;
        start1     = 1'b0;
        xpos1      = 8'd0;
        ypos1      = 8'd0;
        color1     = 3'd0;
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        check("rst_x", 32'(vga_x), 32'd0);
        check("rst_y", 32'(vga_y), 32'd0);
        check("rst_colour", 32'(vga_colour), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst1_outs", 32'({vga_x1, vga_y1, vga_colour1, vga_plot1, busy1, done1}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic block at (80,100), red.
        draw_block(8'd80, 8'd100, 3'b100, 1'b0);

        // Block at the right/bottom edge: wraps, or clips when enabled.
        draw_block(8'd158, 8'd118, 3'b001, 1'b0);

        // start held high: the second block begins only after done.
        draw_block(8'd10, 8'd20, 3'b010, 1'b1);
        draw_block(8'd245, 8'd235, 3'b101, 1'b0);

        // Reset asserted in the fifth DRAW cycle.
        start      = 1'b1;
        xpos       = 8'd80;
        ypos       = 8'd100;
        color_draw = 3'b100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_plot", 32'(vga_plot), 32'd1);
        check("pre_rst_x", 32'(vga_x), 32'd80);
        check("pre_rst_y", 32'(vga_y), 32'd101);
        resetn = 1'b0;
        #1;
        check("arst_x", 32'(vga_x), 32'd0);
        check("arst_y", 32'(vga_y), 32'd0);
        check("arst_colour", 32'(vga_colour), 32'd0);
        check("arst_plot", 32'(vga_plot), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("post_rst_quiet", 32'({vga_plot, busy, done}), 32'd0);
            @(negedge clk);
        end
        draw_block(8'd80, 8'd100, 3'b100, 1'b0);

        // SIZE=1: one pixel at (0,0), then done in the following cycle.
        start1 = 1'b1;
        xpos1  = 8'd0;
        ypos1  = 8'd0;
        color1 = 3'b011;
        @(negedge clk);
        start1 = 1'b0;
        check("s1_plot", 32'(vga_plot1), 32'd1);
        check("s1_x", 32'(vga_x1), 32'd0);
        check("s1_y", 32'(vga_y1), 32'd0);
        check("s1_colour", 32'(vga_colour1), 32'd3);
        check("s1_done_early", 32'(done1), 32'd0);
        check("s1_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check("s1_done", 32'(done1), 32'd1);
        check("s1_plot_off", 32'(vga_plot1), 32'd0);
        @(negedge clk);
        check("s1_idle", 32'({busy1, done1}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_plotter.md
BLOCK_PLOTTER -- requirements
Module: block_plotter

Interface
REQ-001 Parameter: SIZE, 4, side length in pixels of the square block drawn per request (1..16).
REQ-002 Parameter: X_MAX, 160, screen width in pixels; valid x is 0..X_MAX-1.
REQ-003 Parameter: Y_MAX, 120, screen height in pixels; valid y is 0..Y_MAX-1.
REQ-004 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-006 Port: start  input  1  draw request, sampled every cycle.
REQ-007 Port: xpos  input  8  block top-left x, sampled on accepted start.
REQ-008 Port: ypos  input  8  block top-left y, sampled on accepted start.
REQ-009 Port: color_draw  input  3  block colour (RGB), sampled on accepted start.
REQ-010 Port: vga_x  output  8  pixel x to VGA adapter.
REQ-011 Port: vga_y  output  7  pixel y to VGA adapter.
REQ-012 Port: vga_colour  output  3  pixel colour to VGA adapter.
REQ-013 Port: vga_plot  output  1  pixel write strobe to VGA adapter.
REQ-014 Port: busy  output  1  high while a request is in progress.
REQ-015 Port: done  output  1  one-cycle pulse when a block completes.

Function
REQ-016 FSM states: IDLE, DRAW, DONE; all outputs registered.
REQ-017 IDLE: start=1 latches xpos, ypos, color_draw, clears column counter cx and row counter cy, next state DRAW.
REQ-018 start while busy=1 is ignored; no queuing; latched values unchanged.
REQ-019 DRAW: each cycle emits one pixel at (x0+cx, y0+cy) with vga_plot=1, vga_colour=latched colour.
REQ-020 Scan order row-major: cx increments each cycle; at cx=SIZE-1, cx wraps to 0 and cy increments.
REQ-021 After pixel (SIZE-1, SIZE-1), next state DONE; DRAW lasts exactly SIZE*SIZE cycles.
REQ-022 Latency: start accepted in cycle N -> first vga_plot=1 in cycle N+1; done=1 in cycle N+1+SIZE*SIZE.
REQ-023 DONE: done=1, vga_plot=0 for one cycle, then IDLE; start in DONE cycle is ignored.
REQ-024 busy=1 in DRAW and DONE, 0 in IDLE; a new start is accepted earliest the cycle after done.
REQ-025 Coordinate sums computed at 9 bits; vga_x takes bits [7:0], vga_y takes bits [6:0].
REQ-026 Outside DRAW, vga_plot=0; vga_x, vga_y, vga_colour hold last values.

Reset
REQ-027 resetn=0 asynchronously forces IDLE, cx=cy=0, latched x0/y0/colour=0, and vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0.
REQ-028 Reset mid-DRAW abandons the block with no done pulse; after release, the block waits for a new start.

Configuration
REQ-029 Macro PLOT_CLIP_EN defined: pixels with x0+cx >= X_MAX or y0+cy >= Y_MAX emit vga_plot=0 for that cycle; cycle count and done timing unchanged.
REQ-030 Macro PLOT_CLIP_EN undefined: every DRAW cycle has vga_plot=1; coordinates are truncated per REQ-025 with no clipping.

Verification
REQ-031 SIZE=4, start with xpos=80, ypos=100, colour=3'b100 -> 16 consecutive plots (80,100),(81,100)..(83,103) in row-major order, colour 100, done in the 17th cycle after start.
REQ-032 start held high continuously -> second block begins the cycle after done, never mid-block; xpos changed during DRAW has no effect.
REQ-033 PLOT_CLIP_EN, xpos=158, ypos=118 -> 4 plots at (158..159, 118..119) only, done still 17 cycles after start.
REQ-034 Without PLOT_CLIP_EN, xpos=158 -> 16 plots, including vga_x=160 and 161.
REQ-035 resetn low for 1 cycle at 5th DRAW cycle -> all outputs 0 immediately, no done pulse; next start draws a full 16-pixel block.
REQ-036 SIZE=1, xpos=0, ypos=0 -> single plot at (0,0) the cycle after start, done the following cycle.
